code_loader: RTL and testbench

- Boot-time program loader upstream of the processor's code memory.
- Consumes a byte stream from a UART receiver, packs bytes into 18-bit code words and writes them sequentially into code RAM through a write port.
- Holds the processor in reset until a frame has loaded cleanly, then releases it.
- Frame format: sync 0xA5, length (2 bytes LE, word count), 3 bytes LE per word, 1-byte XOR checksum.

---
 rtl/code_loader_pkg.sv | 20 ++
 rtl/loader_word_pack.sv | 43 ++++
 rtl/code_loader.sv | 179 +++++++++++++++++
 tb/tb_code_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
// Shared types and constants for the boot-time code loader.
// Imported by the loader top and its word packer.
package code_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    CHK,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 3;

endpackage

// File: rtl/loader_word_pack.sv
// Byte-lane accumulator: packs three LE bytes into an 18-bit word.
// The top lane only carries bits [17:16]; any higher bit set is a bad byte.
module loader_word_pack
  import code_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  output logic [17:0] word,
  output logic        word_ready,
  output logic        bad_byte
);

  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic       last_lane;

  assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    b0_d = b0_q;
    b1_d = b1_q;
    if (byte_valid && lane == 2'd0) b0_d = data;
    if (byte_valid && lane == 2'd1) b1_d = data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b0_q <= '0;
      b1_q <= '0;
    end else begin
      b0_q <= b0_d;
      b1_q <= b1_d;
    end
  end

  assign word       = {data[1:0], b1_q, b0_q};
  assign word_ready = byte_valid && last_lane && (data[7:2] == 6'd0);
  assign bad_byte   = byte_valid && last_lane && (data[7:2] != 6'd0);

endmodule

// File: rtl/code_loader.sv
// Boot loader: parses a UART frame, writes code RAM, and holds the
// processor in reset until a frame with a valid checksum has loaded.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_SIZE      = 18,
  parameter int WORD_SIZE      = 18,
  parameter int MEM_SIZE       = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_din,
  output logic                 processor_reset,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [15:0]          len_q, len_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic [7:0]           chk_q, chk_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] din_q, din_d;
  logic                 prst_q, prst_d;
  logic                 done_q, done_d;

  logic        busy_w;
  logic [15:0] len_w;
  logic [1:0]  lane;
  logic        pack_valid;
  logic [17:0] word;
  logic        word_ready;
  logic        bad_byte;
  logic        last_word;

  assign busy_w     = !(state_q inside {IDLE, DONE, ERROR});
  assign len_w      = {rx_data, len_lo_q};
  assign pack_valid = rx_valid && (state_q inside {B0, B1, B2});
  assign lane       = (state_q == B0) ? 2'd0 :
                      (state_q == B1) ? 2'd1 : 2'd2;
  assign last_word  = (idx_q == ADDR_SIZE'(len_q) - ADDR_SIZE'(1));

  loader_word_pack u_pack (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (pack_valid),
    .lane       (lane),
    .data       (rx_data),
    .word       (word),
    .word_ready (word_ready),
    .bad_byte   (bad_byte)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    tmo_d    = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    prst_d   = prst_q;
    done_d   = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = LEN_LO;
            idx_d   = '0;
            chk_d   = '0;
          end
        end
        LEN_LO: begin
          len_lo_d = rx_data;
          chk_d    = chk_q ^ rx_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          len_d = len_w;
          chk_d = chk_q ^ rx_data;
          if (len_w == 16'd0 || 32'(len_w) > MEM_SIZE) state_d = ERROR;
          else state_d = B0;
        end
        B0: begin
          chk_d   = chk_q ^ rx_data;
          state_d = B1;
        end
        B1: begin
          chk_d   = chk_q ^ rx_data;
          state_d = B2;
        end
        B2: begin
          chk_d = chk_q ^ rx_data;
          if (bad_byte) begin
            state_d = ERROR;
          end else if (word_ready) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            din_d   = WORD_SIZE'(word);
            idx_d   = idx_q + ADDR_SIZE'(1);
            state_d = last_word ? CHK : B0;
          end
        end
        CHK: begin
          if (rx_data == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            prst_d  = 1'b0;
          end else begin
            state_d = ERROR;
          end
        end
        DONE, ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = LEN_LO;
            idx_d   = '0;
            chk_d   = '0;
            prst_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (busy_w) begin
      // Gap between bytes inside a frame; abandon the frame when it runs out.
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      else tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      prst_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      prst_q   <= prst_d;
      done_q   <= done_d;
    end
  end

  assign code_we         = we_q;
  assign code_addr       = addr_q;
  assign code_din        = din_q;
  assign processor_reset = prst_q;
  assign busy            = busy_w;
  assign load_done       = done_q;
  assign load_error      = (state_q == ERROR);

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: frames, checksum, length, bad byte,
// timeout, back-to-back stream and mid-frame reset.
module tb_code_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        code_we;
  logic [17:0] code_addr;
  logic [17:0] code_din;
  logic        processor_reset;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int n_chk = 0;
  int n_fail = 0;
  int dones = 0;
  logic [17:0] wa[$];
  logic [17:0] wd[$];

  always #5 clock = ~clock;

  code_loader #(
    .ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(1024), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .code_we(code_we), .code_addr(code_addr), .code_din(code_din),
    .processor_reset(processor_reset), .busy(busy),
    .load_done(load_done), .load_error(load_error)
  );

  always @(negedge clock) begin
    if (code_we === 1'b1) begin
      wa.push_back(code_addr);
      wd.push_back(code_din);
    end
    if (load_done === 1'b1) dones++;
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    dones = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    n_chk++; if (code_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", code_we); end
    n_chk++; if (code_addr !== 18'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", code_addr); end
    n_chk++; if (code_din !== 18'd0) begin n_fail++; $display("FAIL rst_din: got %h want 0", code_din); end
    n_chk++; if (processor_reset !== 1'b1) begin n_fail++; $display("FAIL rst_prst: got %b want 1", processor_reset); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", load_done); end
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", load_error); end
    reset = 1'b0;
    idle(1);
    clear_log();
  endtask

  task automatic send_two_words();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h01);
    send(8'hFF); send(8'hFF); send(8'h03);
  endtask

  task automatic check_two_words(input string tag);
    n_chk++; if (wa.size() !== 2) begin n_fail++; $display("FAIL %s_wcount: got %0d want 2", tag, wa.size()); end
    else begin
      n_chk++; if (wa[0] !== 18'd0 || wd[0] !== 18'h11234) begin n_fail++; $display("FAIL %s_w0: got %h@%h want 11234@0", tag, wd[0], wa[0]); end
      n_chk++; if (wa[1] !== 18'd1 || wd[1] !== 18'h3FFFF) begin n_fail++; $display("FAIL %s_w1: got %h@%h want 3ffff@1", tag, wd[1], wa[1]); end
    end
  endtask

  task automatic test_good_frame();
    clear_log();
    send_two_words();
    n_chk++; if (busy !== 1'b1 || processor_reset !== 1'b1) begin n_fail++; $display("FAIL good_pre: busy=%b prst=%b want 1 1", busy, processor_reset); end
    send(8'h26);
    n_chk++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL good_done: got %b want 1", load_done); end
    n_chk++; if (processor_reset !== 1'b0) begin n_fail++; $display("FAIL good_prst: got %b want 0", processor_reset); end
    n_chk++; if (load_error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL good_flags: err=%b busy=%b want 0 0", load_error, busy); end
    idle(1);
    n_chk++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL good_pulse: got %b want 0", load_done); end
    check_two_words("good");
  endtask

  task automatic test_bad_checksum();
    clear_log();
    send(8'hA5);
    n_chk++; if (processor_reset !== 1'b1) begin n_fail++; $display("FAIL badchk_prst_resync: got %b want 1", processor_reset); end
    send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h01);
    send(8'hFF); send(8'hFF); send(8'h03);
    send(8'h29);
    idle(1);
    n_chk++; if (load_error !== 1'b1 || processor_reset !== 1'b1) begin n_fail++; $display("FAIL badchk_err: err=%b prst=%b want 1 1", load_error, processor_reset); end
    n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL badchk_done: got %0d pulses want 0", dones); end
    check_two_words("badchk");
  endtask

  task automatic test_bad_length();
    clear_log();
    send(8'hA5); send(8'h01);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len_busy: got %b want 1", busy); end
    send(8'h04);
    n_chk++; if (load_error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL len_err: err=%b busy=%b want 1 0", load_error, busy); end
    send(8'h10); send(8'h20); send(8'h00);
    idle(2);
    n_chk++; if (wa.size() !== 0) begin n_fail++; $display("FAIL len_nowrite: got %0d writes want 0", wa.size()); end
  endtask

  task automatic test_bad_word();
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h01);
    send(8'h55); send(8'h66);
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL word_early: got %b want 0", load_error); end
    send(8'h04);
    n_chk++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL word_err: got %b want 1", load_error); end
    idle(2);
    n_chk++; if (wa.size() !== 1) begin n_fail++; $display("FAIL word_wcount: got %0d want 1", wa.size()); end
    else begin
      n_chk++; if (wa[0] !== 18'd0 || wd[0] !== 18'h11234) begin n_fail++; $display("FAIL word_w0: got %h@%h want 11234@0", wd[0], wa[0]); end
    end
  endtask

  task automatic test_timeout();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    idle(15);
    n_chk++; if (busy !== 1'b1 || load_error !== 1'b0) begin n_fail++; $display("FAIL tmo_15: busy=%b err=%b want 1 0", busy, load_error); end
    idle(1);
    n_chk++; if (load_error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_16: err=%b busy=%b want 1 0", load_error, busy); end
    n_chk++; if (wa.size() !== 0) begin n_fail++; $display("FAIL tmo_nowrite: got %0d want 0", wa.size()); end
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h10); send(8'h20); send(8'h03);
    send(8'h32);
    n_chk++; if (load_done !== 1'b1 || processor_reset !== 1'b0) begin n_fail++; $display("FAIL tmo_recover: done=%b prst=%b want 1 0", load_done, processor_reset); end
    n_chk++; if (wa.size() !== 1 || wd[0] !== 18'h32010 || wa[0] !== 18'd0) begin n_fail++; $display("FAIL tmo_word: count=%0d want 1 word 32010@0", wa.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [14];
    logic [17:0] exp_w [4];
    bytes = '{8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h00, 8'h03, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h02};
    exp_w = '{18'h00001, 18'h00002, 18'h10003, 18'h2A5A5};
    clear_log();
    send(8'hA5);
    for (int i = 0; i < 14; i++) send(bytes[i]);
    send(8'h07);
    n_chk++; if (load_done !== 1'b1 || processor_reset !== 1'b0) begin n_fail++; $display("FAIL b2b_done: done=%b prst=%b want 1 0", load_done, processor_reset); end
    n_chk++; if (wa.size() !== 4) begin n_fail++; $display("FAIL b2b_wcount: got %0d want 4", wa.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (wa[i] !== 18'(i) || wd[i] !== exp_w[i]) begin n_fail++; $display("FAIL b2b_w%0d: got %h@%h want %h@%0d", i, wd[i], wa[i], exp_w[i], i); end
      end
    end
    send(8'hA5); send(8'h04); send(8'h00); send(8'h11); send(8'h22);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: busy=%b want 1", busy); end
    reset = 1'b1;
    #1;
    n_chk++; if (processor_reset !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: prst=%b busy=%b want 1 0", processor_reset, busy); end
    n_chk++; if (code_we !== 1'b0 || code_addr !== 18'd0 || code_din !== 18'd0) begin n_fail++; $display("FAIL midrst_port: we=%b addr=%h din=%h want 0 0 0", code_we, code_addr, code_din); end
    n_chk++; if (load_done !== 1'b0 || load_error !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: done=%b err=%b want 0 0", load_done, load_error); end
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    n_chk++; if (busy !== 1'b0 || processor_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_post: busy=%b prst=%b want 0 1", busy, processor_reset); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_bad_word();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
